// File: rtl/rv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// rv_multicycle_ctrl
//
// Multicycle control unit for an RV32I core. Each instruction is walked
// through FETCH -> DECODE -> EXEC -> (MEM) -> WB, or FETCH -> DECODE -> EXEC
// -> BR for branches. The unit supports R-type, I-type ALU, LW, SW and
// BEQ/BNE/BLT/BGE. Any other encoding either locks the unit in a sticky TRAP
// state or retires as a NOP, depending on TRAP_ON_ILLEGAL.
//
// All outputs are Moore outputs decoded from the state register and the
// instruction register. None of them depends combinationally on an ack or
// ALU-flag input. The one exception is the asynchronous reset, which forces
// the fetch request low while reset is asserted.
//
// Parameters:
//   TRAP_ON_ILLEGAL  1: an unsupported encoding enters a sticky TRAP state.
//                    0: an unsupported encoding retires as a NOP (PC+4, no
//                       writes).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   imem_req/ack/rdata  instruction fetch handshake and fetched word
//   dmem_re/we/ack      data memory read/write request and completion
//   alu_ctrl            ALU operation code {funct7, funct3}
//   imm, imm_en         sign-extended immediate and ALU operand-B select
//   alu_z, alu_n        ALU zero and negative flags, used for branches
//   rs1, rs2, rd        register-file addresses taken from the IR
//   reg_we, wb_sel      register write strobe and writeback source
//   pc_we, pc_sel       PC update strobe and next-PC select
//   trap                sticky illegal-instruction flag
// -----------------------------------------------------------------------------
module rv_multicycle_ctrl #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_re,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [9:0]  alu_ctrl,
  output logic [31:0] imm,
  output logic        imm_en,
  input  logic        alu_z,
  input  logic        alu_n,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        trap
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BR,
    S_TRAP
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] ir_reg, ir_next;
  logic        taken_reg, taken_next;

  // ---------------------------------------------------------------------------
  // Instruction classification, decoded from the IR
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_r, is_i, is_ld, is_st, is_br, is_legal;
  logic [31:0] imm_dec;
  logic [9:0]  alu_dec;
  logic        en_dec;
  logic        br_cond;

  assign opcode = ir_reg[6:0];
  assign funct3 = ir_reg[14:12];

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD)  && (funct3 == 3'b010);
  assign is_st    = (opcode == OP_STORE) && (funct3 == 3'b010);
  assign is_br    = (opcode == OP_BRANCH) &&
                    ((funct3 == 3'b000) || (funct3 == 3'b001) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101));
  assign is_legal = is_r || is_i || is_ld || is_st || is_br;

  assign rs1 = ir_reg[19:15];
  assign rs2 = ir_reg[24:20];
  assign rd  = ir_reg[11:7];

  always_comb begin
    imm_dec = 32'd0;
    if (is_i || is_ld) begin
      imm_dec = {{20{ir_reg[31]}}, ir_reg[31:20]};
    end else if (is_st) begin
      imm_dec = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
    end else if (is_br) begin
      imm_dec = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25],
                 ir_reg[11:8], 1'b0};
    end
  end

  always_comb begin
    alu_dec = 10'd0;
    en_dec  = 1'b0;
    if (is_r) begin
      alu_dec = {ir_reg[31:25], funct3};
    end else if (is_i) begin
      en_dec = 1'b1;
      // Only the shift-right group keeps funct7, so SRLI/SRAI are distinguished
      // by ir[30]. Every other I-ALU op carries immediate bits in ir[31:25],
      // and those bits must not leak into the ALU code.
      if (funct3 == 3'b101) begin
        alu_dec = {ir_reg[31:25], 3'b101};
      end else begin
        alu_dec = {7'd0, funct3};
      end
    end else if (is_ld || is_st) begin
      alu_dec = 10'b0000000_000;
      en_dec  = 1'b1;
    end else if (is_br) begin
      alu_dec = 10'b0100000_000;
    end
  end

  // BLT/BGE use the raw sign of rs1-rs2. Signed overflow is not corrected.
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = alu_z;
      3'b001:  br_cond = !alu_z;
      3'b100:  br_cond = alu_n;
      3'b101:  br_cond = !alu_n;
      default: br_cond = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      ir_reg    <= 32'd0;
      taken_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
      taken_reg <= taken_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    taken_next = taken_reg;
    case (state_reg)
      S_FETCH: begin
        if (imem_ack) begin
          ir_next    = imem_rdata;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_next = S_EXEC;
        end else if (TRAP_ON_ILLEGAL) begin
          state_next = S_TRAP;
        end else begin
          state_next = S_WB;
        end
      end
      S_EXEC: begin
        if (is_ld || is_st) begin
          state_next = S_MEM;
        end else if (is_br) begin
          taken_next = br_cond;
          state_next = S_BR;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_next = S_WB;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_BR:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // While reset is held, the unit sits in FETCH but must not request a fetch.
    imem_req = (state_reg == S_FETCH) && !rst;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    alu_ctrl = 10'd0;
    imm_en   = 1'b0;
    imm      = (state_reg == S_FETCH) ? 32'd0 : imm_dec;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    trap     = (state_reg == S_TRAP);
    case (state_reg)
      S_EXEC: begin
        alu_ctrl = alu_dec;
        imm_en   = en_dec;
      end
      S_MEM: begin
        alu_ctrl = alu_dec;
        imm_en   = en_dec;
        dmem_re  = is_ld;
        dmem_we  = is_st;
      end
      S_WB: begin
        alu_ctrl = alu_dec;
        imm_en   = en_dec;
        pc_we    = 1'b1;
        // An illegal instruction retiring as a NOP matches none of these
        // classes, so it writes nothing.
        reg_we   = (is_r || is_i || is_ld) && (rd != 5'd0);
        wb_sel   = is_ld;
      end
      S_BR: begin
        pc_we  = 1'b1;
        pc_sel = taken_reg;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for rv_multicycle_ctrl. A table of directed instruction vectors
// drives the main instance (TRAP_ON_ILLEGAL=1). Hand-written sequences cover
// reset, the sticky trap, reset in the middle of a store, and the NOP
// behaviour of a second instance built with TRAP_ON_ILLEGAL=0.
// -----------------------------------------------------------------------------
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_re, dmem_we, dmem_ack;
  logic [9:0]  alu_ctrl;
  logic [31:0] imm;
  logic        imm_en, alu_z, alu_n;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_we, wb_sel, pc_we, pc_sel, trap;

  logic        n_imem_req, n_imem_ack;
  logic [31:0] n_imem_rdata;
  logic        n_dmem_re, n_dmem_we;
  logic [9:0]  n_alu_ctrl;
  logic [31:0] n_imm;
  logic        n_imm_en;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic        n_reg_we, n_wb_sel, n_pc_we, n_pc_sel, n_trap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_ctrl(alu_ctrl), .imm(imm), .imm_en(imm_en),
    .alu_z(alu_z), .alu_n(alu_n),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap)
  );

  rv_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .rst(rst),
    .imem_req(n_imem_req), .imem_ack(n_imem_ack), .imem_rdata(n_imem_rdata),
    .dmem_re(n_dmem_re), .dmem_we(n_dmem_we), .dmem_ack(dmem_ack),
    .alu_ctrl(n_alu_ctrl), .imm(n_imm), .imm_en(n_imm_en),
    .alu_z(alu_z), .alu_n(alu_n),
    .rs1(n_rs1), .rs2(n_rs2), .rd(n_rd),
    .reg_we(n_reg_we), .wb_sel(n_wb_sel), .pc_we(n_pc_we), .pc_sel(n_pc_sel),
    .trap(n_trap)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        z;
    logic        n;
    int          wait_n;   // extra dmem_ack wait cycles
    logic        noise;    // hold both acks high outside the real handshakes
    logic [9:0]  alu;
    logic [31:0] imm;
    logic        imm_en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        wb_sel;
    logic        pc_sel;
    int          re_cyc;
    int          we_cyc;
    int          cycles;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc = 0, end_cyc = 0, re_cnt = 0, we_cnt = 0, mem_cnt = 0;
    int regwe_cnt = 0;
    bit done = 0;
    logic [31:0] imm_d = '0;
    logic [9:0]  alu_d = '0, alu_x = '0;
    logic        en_x = 1'b0;
    logic [4:0]  rs1_x = '0, rs2_x = '0, rd_w = '0;
    logic        reg_we_w = 1'b0, wb_sel_w = 1'b0, pc_sel_w = 1'b0;
    check({v.name, ".fetch_req"}, {31'd0, imem_req}, 32'd1);
    imem_rdata = v.instr;
    imem_ack   = 1'b1;
    dmem_ack   = v.noise;
    alu_z      = v.z;
    alu_n      = v.n;
    while (!done && cyc < 40) begin
      step();
      cyc++;
      if (v.noise) begin
        // An ack taken outside FETCH would load this garbage word.
        imem_rdata = 32'hFFFF_FFFF;
      end else begin
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
      end
      if (cyc == 1) begin
        imm_d = imm;
        alu_d = alu_ctrl;
      end
      if (cyc == 2) begin
        alu_x = alu_ctrl;
        en_x  = imm_en;
        rs1_x = rs1;
        rs2_x = rs2;
      end
      if (dmem_re) re_cnt++;
      if (dmem_we) we_cnt++;
      if (dmem_re || dmem_we) begin
        mem_cnt++;
        if (mem_cnt == v.wait_n + 1) dmem_ack = 1'b1;
      end
      if (reg_we) regwe_cnt++;
      if (pc_we) begin
        reg_we_w = reg_we;
        wb_sel_w = wb_sel;
        pc_sel_w = pc_sel;
        rd_w     = rd;
        end_cyc  = cyc;
        done     = 1;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    check({v.name, ".completed"}, {31'd0, done}, 32'd1);
    check({v.name, ".imm_decode"}, imm_d, v.imm);
    check({v.name, ".alu_decode"}, {22'd0, alu_d}, 32'd0);
    check({v.name, ".alu_exec"}, {22'd0, alu_x}, {22'd0, v.alu});
    check({v.name, ".imm_en_exec"}, {31'd0, en_x}, {31'd0, v.imm_en});
    check({v.name, ".rs1"}, {27'd0, rs1_x}, {27'd0, v.rs1});
    check({v.name, ".rs2"}, {27'd0, rs2_x}, {27'd0, v.rs2});
    check({v.name, ".rd"}, {27'd0, rd_w}, {27'd0, v.rd});
    check({v.name, ".reg_we"}, {31'd0, reg_we_w}, {31'd0, v.reg_we});
    check({v.name, ".reg_we_pulses"}, regwe_cnt, {31'd0, v.reg_we});
    check({v.name, ".wb_sel"}, {31'd0, wb_sel_w}, {31'd0, v.wb_sel});
    check({v.name, ".pc_sel"}, {31'd0, pc_sel_w}, {31'd0, v.pc_sel});
    check({v.name, ".dmem_re_cycles"}, re_cnt, v.re_cyc);
    check({v.name, ".dmem_we_cycles"}, we_cnt, v.we_cyc);
    check({v.name, ".latency"}, end_cyc + 1, v.cycles);
    step();
    check({v.name, ".refetch_req"}, {31'd0, imem_req}, 32'd1);
    check({v.name, ".refetch_pc_we"}, {31'd0, pc_we}, 32'd0);
    $display("vec %-8s instr=0x%08h alu=0x%03h imm=0x%08h cycles=%0d",
             v.name, v.instr, alu_x, imm_d, end_cyc + 1);
  endtask

  // Illegal encodings on the NOP-mode instance: FETCH, DECODE, then straight
  // to WB with only a PC+4 update.
  task automatic run_nop(input string name, input logic [31:0] instr);
    check({name, ".req"}, {31'd0, n_imem_req}, 32'd1);
    n_imem_rdata = instr;
    n_imem_ack   = 1'b1;
    step();
    n_imem_ack = 1'b0;
    check({name, ".decode_pc_we"}, {31'd0, n_pc_we}, 32'd0);
    step();
    check({name, ".wb_strobes"},
          {27'd0, n_pc_we, n_reg_we, n_pc_sel, n_dmem_re, n_dmem_we},
          32'b10000);
    check({name, ".wb_alu"}, {22'd0, n_alu_ctrl}, 32'd0);
    check({name, ".no_trap"}, {31'd0, n_trap}, 32'd0);
    step();
    check({name, ".refetch"}, {31'd0, n_imem_req}, 32'd1);
    $display("nop %s instr=0x%08h retired", name, instr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  seen;

    vecs[0]  = '{"add",     32'h002081B3, 0, 0, 0, 1, 10'h000, 32'h0000_0000, 0, 1, 2, 3,  1, 0, 0, 0, 0, 4};
    vecs[1]  = '{"sub",     32'h402081B3, 0, 0, 0, 0, 10'h100, 32'h0000_0000, 0, 1, 2, 3,  1, 0, 0, 0, 0, 4};
    vecs[2]  = '{"srai",    32'h40335293, 0, 0, 0, 1, 10'h105, 32'h0000_0403, 1, 6, 3, 5,  1, 0, 0, 0, 0, 4};
    vecs[3]  = '{"addi_x0", 32'h00508013, 0, 0, 0, 0, 10'h000, 32'h0000_0005, 1, 1, 5, 0,  0, 0, 0, 0, 0, 4};
    vecs[4]  = '{"andi",    32'hFFF47393, 0, 0, 0, 1, 10'h007, 32'hFFFF_FFFF, 1, 8, 31, 7, 1, 0, 0, 0, 0, 4};
    vecs[5]  = '{"lw",      32'h00812203, 0, 0, 3, 0, 10'h000, 32'h0000_0008, 1, 2, 8, 4,  1, 1, 0, 4, 0, 8};
    vecs[6]  = '{"sw",      32'h0020A223, 0, 0, 0, 0, 10'h000, 32'h0000_0004, 1, 1, 2, 4,  0, 0, 0, 0, 1, 5};
    vecs[7]  = '{"beq_t",   32'hFE208CE3, 1, 0, 0, 1, 10'h100, 32'hFFFF_FFF8, 0, 1, 2, 25, 0, 0, 1, 0, 0, 4};
    vecs[8]  = '{"beq_nt",  32'hFE208CE3, 0, 0, 0, 0, 10'h100, 32'hFFFF_FFF8, 0, 1, 2, 25, 0, 0, 0, 0, 0, 4};
    vecs[9]  = '{"bne_t",   32'hFE209CE3, 0, 0, 0, 0, 10'h100, 32'hFFFF_FFF8, 0, 1, 2, 25, 0, 0, 1, 0, 0, 4};
    vecs[10] = '{"blt_t",   32'hFE20CCE3, 0, 1, 0, 1, 10'h100, 32'hFFFF_FFF8, 0, 1, 2, 25, 0, 0, 1, 0, 0, 4};
    vecs[11] = '{"bge_nt",  32'hFE20DCE3, 0, 1, 0, 0, 10'h100, 32'hFFFF_FFF8, 0, 1, 2, 25, 0, 0, 0, 0, 0, 4};

    rst          = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'd0;
    dmem_ack     = 1'b0;
    alu_z        = 1'b0;
    alu_n        = 1'b0;
    n_imem_ack   = 1'b0;
    n_imem_rdata = 32'd0;

    // Reset state
    repeat (2) step();
    check("rst.imem_req", {31'd0, imem_req}, 32'd0);
    check("rst.nop_imem_req", {31'd0, n_imem_req}, 32'd0);
    check("rst.strobes", {26'd0, trap, pc_we, reg_we, dmem_re, dmem_we, imm_en},
          32'd0);
    check("rst.alu_ctrl", {22'd0, alu_ctrl}, 32'd0);
    check("rst.imm", imm, 32'd0);
    check("rst.regs", {17'd0, rs1, rs2, rd}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst.release_req", {31'd0, imem_req}, 32'd1);
    step();
    check("rst.idle_fetch", {31'd0, imem_req}, 32'd1);
    $display("reset checked");

    // Table-driven instruction vectors
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // Illegal encodings retire as NOPs when TRAP_ON_ILLEGAL=0
    run_nop("nop_ones", 32'hFFFF_FFFF);
    run_nop("nop_lb", 32'h0081_0203);

    // Sticky trap: stray acks are ignored, only reset leaves TRAP
    imem_rdata = 32'hFFFF_FFFF;
    imem_ack   = 1'b1;
    step();
    check("trap.decode", {31'd0, trap}, 32'd0);
    dmem_ack = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      check("trap.hold", {28'd0, trap, imem_req, pc_we, reg_we}, 32'b1000);
      step();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("trap.async_clear", {31'd0, trap}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("trap.resume_fetch", {31'd0, imem_req}, 32'd1);
    $display("trap sequence done");

    // Reset in the middle of a store
    imem_rdata = 32'h0020A223;
    imem_ack   = 1'b1;
    step();
    imem_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (dmem_we) seen = 1;
    end
    check("rststore.reach_mem", {31'd0, seen}, 32'd1);
    step();
    check("rststore.we_held", {31'd0, dmem_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rststore.we_async_drop", {31'd0, dmem_we}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rststore.fetch_req", {31'd0, imem_req}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (reg_we || pc_we || dmem_we) cnt++;
    end
    check("rststore.no_writeback", cnt, 32'd0);
    check("rststore.still_fetch", {31'd0, imem_req}, 32'd1);
    $display("reset-during-store sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
